sccb_master: RTL and testbench

SCCB_MASTER -- requirements
Module: sccb_master

---
 rtl/sccb_pkg.sv | 24 ++
 rtl/sccb_tick_gen.sv | 31 +++
 rtl/sccb_master.sv | 163 ++++++++++++++++
 tb/tb_sccb_master.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sccb_pkg.sv
// Shared types and helpers for the SCCB write-only master.
// Holds the controller state encoding and the bit-rate divider calculation.
package sccb_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      TX_BYTE,
      DONT_CARE,
      STOP,
      GAP
   } state_t;

   // Index of the byte being sent: 0 = device id, 1 = sub-address, 2 = write data.
   typedef logic [1:0] phase_t;

   localparam phase_t LAST_PHASE = 2'd2;

   function automatic int calc_quarter_cycles(input int clk_frequency,
                                              input int sccb_frequency);
      return clk_frequency / (4 * sccb_frequency);
   endfunction

endpackage

// File: rtl/sccb_tick_gen.sv
// Quarter-bit timebase: one-cycle tick every QUARTER_CYCLES clocks.
// Held at zero while cleared so each transaction starts on a fresh quarter.
module sccb_tick_gen #(
   parameter int QUARTER_CYCLES = 62
) (
   input  logic i_clk,
   input  logic i_reset_n,
   input  logic i_clear,
   output logic o_tick
);

   localparam int CNT_W = (QUARTER_CYCLES > 2) ? $clog2(QUARTER_CYCLES) : 1;
   localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(QUARTER_CYCLES - 1);

   logic [CNT_W-1:0] count_q;

   assign o_tick = !i_clear && (count_q == LAST_COUNT);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of its peers.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         count_q <= '0;
      end else if (i_clear || o_tick) begin
         count_q <= '0;
      end else begin
         count_q <= count_q + 1'b1;
      end
   end

endmodule

// File: rtl/sccb_master.sv
// SCCB 3-phase write master: START, device id, sub-address, data, STOP, bus-free gap.
// The 9th bit of each phase releases SIO_D and is never sampled.
module sccb_master
   import sccb_pkg::*;
#(
   parameter int         CLK_FREQUENCY  = 25000000,
   parameter int         SCCB_FREQUENCY = 100000,
   parameter logic [7:0] DEVICE_ID      = 8'h42
) (
   input  logic       i_clk,
   input  logic       i_reset_n,
   input  logic       i_start,
   input  logic [7:0] i_address,
   input  logic [7:0] i_data,
   output logic       o_ready,
   output logic       o_sioc,
   output logic       o_siod,
   output logic       o_siod_oe
);

   localparam int QUARTER_CYCLES = calc_quarter_cycles(CLK_FREQUENCY, SCCB_FREQUENCY);

   generate
      if (QUARTER_CYCLES < 2) begin : g_bad_rate
         $error("sccb_master: CLK_FREQUENCY/(4*SCCB_FREQUENCY) must be at least 2");
      end
   endgenerate

   state_t     state_q, state_d;
   logic [1:0] quarter_q, quarter_d;
   logic [2:0] bit_q, bit_d;
   phase_t     phase_q, phase_d;
   logic [7:0] address_q, data_q;
   logic       idle, accept, tick, slot_end;
   logic [7:0] cur_byte;
   logic       ready_d, sioc_d, siod_d, oe_d;

   assign idle     = (state_q == IDLE);
   assign accept   = idle && i_start;
   assign slot_end = tick && (quarter_q == 2'd3);

   sccb_tick_gen #(
      .QUARTER_CYCLES(QUARTER_CYCLES)
   ) u_tick_gen (
      .i_clk    (i_clk),
      .i_reset_n(i_reset_n),
      .i_clear  (idle),
      .o_tick   (tick)
   );

   // NOTE: every signal driven here gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_d   = state_q;
      quarter_d = quarter_q;
      bit_d     = bit_q;
      phase_d   = phase_q;
      if (tick) quarter_d = quarter_q + 2'd1;

      case (state_q)
         IDLE: begin
            quarter_d = 2'd0;
            bit_d     = 3'd0;
            phase_d   = '0;
            if (i_start) state_d = START;
         end
         START: begin
            if (slot_end) state_d = TX_BYTE;
         end
         TX_BYTE: begin
            if (slot_end) begin
               bit_d = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = DONT_CARE;
            end
         end
         DONT_CARE: begin
            if (slot_end) begin
               if (phase_q == LAST_PHASE) begin
                  state_d = STOP;
               end else begin
                  state_d = TX_BYTE;
                  phase_d = phase_q + 2'd1;
               end
            end
         end
         STOP: begin
            if (slot_end) state_d = GAP;
         end
         GAP: begin
            if (slot_end) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so the registered lines
   // line up exactly with quarter boundaries.
   always_comb begin
      case (phase_d)
         2'd0:    cur_byte = DEVICE_ID;
         2'd1:    cur_byte = address_q;
         default: cur_byte = data_q;
      endcase

      ready_d = (state_d == IDLE);
      sioc_d  = 1'b1;
      siod_d  = 1'b1;
      oe_d    = 1'b1;
      case (state_d)
         START: begin
            siod_d = !quarter_d[1];
         end
         TX_BYTE: begin
            sioc_d = quarter_d[1];
            siod_d = cur_byte[3'd7 - bit_d];
         end
         DONT_CARE: begin
            sioc_d = quarter_d[1];
            oe_d   = 1'b0;
         end
         STOP: begin
            sioc_d = quarter_d[1];
            siod_d = (quarter_d == 2'd3);
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q   <= IDLE;
         quarter_q <= 2'd0;
         bit_q     <= 3'd0;
         phase_q   <= '0;
         address_q <= 8'h00;
         data_q    <= 8'h00;
      end else begin
         state_q   <= state_d;
         quarter_q <= quarter_d;
         bit_q     <= bit_d;
         phase_q   <= phase_d;
         if (accept) begin
            address_q <= i_address;
            data_q    <= i_data;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         o_ready   <= 1'b1;
         o_sioc    <= 1'b1;
         o_siod    <= 1'b1;
         o_siod_oe <= 1'b1;
      end else begin
         o_ready   <= ready_d;
         o_sioc    <= sioc_d;
         o_siod    <= siod_d;
         o_siod_oe <= oe_d;
      end
   end

endmodule

// File: tb/tb_sccb_master.sv
// Bench for sccb_master: per-quarter waveform model checked every cycle,
// plus a bus decoder that rebuilds each frame from SIO_C/SIO_D.
module tb_sccb_master;

   localparam int         CLK_HZ  = 25000000;
   localparam int         SCCB_HZ = 100000;
   localparam int         Q       = CLK_HZ / (4 * SCCB_HZ);
   localparam int         TXN     = 120 * Q;
   localparam logic [7:0] DEV     = 8'h42;

   logic       i_clk = 1'b0;
   logic       i_reset_n = 1'b0;
   logic       i_start = 1'b0;
   logic [7:0] i_address = 8'h00;
   logic [7:0] i_data = 8'h00;
   logic       o_ready, o_sioc, o_siod, o_siod_oe;

   sccb_master #(
      .CLK_FREQUENCY (CLK_HZ),
      .SCCB_FREQUENCY(SCCB_HZ),
      .DEVICE_ID     (DEV)
   ) dut (
      .i_clk    (i_clk),
      .i_reset_n(i_reset_n),
      .i_start  (i_start),
      .i_address(i_address),
      .i_data   (i_data),
      .o_ready  (o_ready),
      .o_sioc   (o_sioc),
      .o_siod   (o_siod),
      .o_siod_oe(o_siod_oe)
   );

   always #5 i_clk = ~i_clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Bus levels {sioc, siod, oe} for quarter qi of a transaction, from the
   // frame layout: START slot, 27 bit slots (8 data + 1 released per byte), STOP, GAP.
   function automatic logic [2:0] wave(input logic [7:0] a, input logic [7:0] d, input int qi);
      int         slot, q, pos, ph;
      logic       hi;
      logic [7:0] b;
      slot = qi / 4;
      q    = qi % 4;
      hi   = (q >= 2);
      if (slot == 0) return {1'b1, (q < 2), 1'b1};
      if (slot <= 27) begin
         pos = (slot - 1) % 9;
         ph  = (slot - 1) / 9;
         if (pos == 8) return {hi, 2'b10};
         b = (ph == 0) ? DEV : ((ph == 1) ? a : d);
         return {hi, b[7-pos], 1'b1};
      end
      if (slot == 28) return {hi, (q == 3), 1'b1};
      return 3'b111;
   endfunction

   // Transaction model: busy for exactly TXN cycles after each accepting edge.
   bit         m_busy = 1'b0;
   int         m_cyc = 0;
   logic [7:0] m_addr = 8'h00, m_data = 8'h00;
   logic [7:0] q_addr[0:15];
   logic [7:0] q_data[0:15];
   int         wr_cnt = 0;

   always @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         m_busy = 1'b0;
         m_cyc  = 0;
      end else if (!m_busy) begin
         if (i_start) begin
            m_busy = 1'b1;
            m_cyc  = 0;
            m_addr = i_address;
            m_data = i_data;
            q_addr[wr_cnt[3:0]] = i_address;
            q_data[wr_cnt[3:0]] = i_data;
            wr_cnt++;
         end
      end else if (m_cyc == TXN - 1) begin
         m_busy = 1'b0;
      end else begin
         m_cyc++;
      end
   end

   always @(negedge i_clk) begin
      logic [2:0] e;
      if (i_reset_n) begin
         e = m_busy ? wave(m_addr, m_data, m_cyc / Q) : 3'b111;
         check("cycle", {28'd0, o_ready, o_sioc, o_siod, o_siod_oe}, {28'd0, !m_busy, e});
      end
   end

   // Bus decoder: START/STOP detection, bit capture on SIO_C rise, period timing.
   logic       p_sioc = 1'b1, p_siod = 1'b1;
   int         run = 0;
   bit         in_frame = 1'b0;
   logic [1:0] bits[$];
   int         oe_low = 0;
   int         rd_idx = 0;
   int         n_frames = 0;
   logic [7:0] b0, b1, b2;
   logic [7:0] last0 = 8'h00, last1 = 8'h00, last2 = 8'h00;
   logic       data_oe, ack_oe;

   always @(negedge i_clk) begin
      if (!i_reset_n) begin
         in_frame = 1'b0;
         bits.delete();
         p_sioc = 1'b1;
         p_siod = 1'b1;
         run    = 0;
         oe_low = 0;
         rd_idx = wr_cnt;
      end else begin
         if (!o_siod_oe) oe_low++;
         if (o_sioc != p_sioc) begin
            if (in_frame) begin
               if (o_sioc) check("sioc_low_period", run, 2 * Q);
               else if (bits.size() > 0) check("sioc_high_period", run, 2 * Q);
               if (o_sioc) bits.push_back({o_siod_oe, o_siod});
            end
            run = 1;
         end else begin
            run++;
         end
         if (p_sioc && o_sioc && (o_siod != p_siod)) begin
            if (!o_siod) begin
               in_frame = 1'b1;
               bits.delete();
               oe_low = 0;
            end else if (in_frame) begin
               check("frame_bits", bits.size(), 28);
               b0 = 8'h00; b1 = 8'h00; b2 = 8'h00;
               data_oe = 1'b1;
               ack_oe  = 1'b0;
               if (bits.size() == 28) begin
                  for (int i = 0; i < 27; i++) begin
                     if (i % 9 == 8) begin
                        ack_oe = ack_oe | bits[i][1];
                     end else begin
                        data_oe = data_oe & bits[i][1];
                        if (i < 9)       b0 = {b0[6:0], bits[i][0]};
                        else if (i < 18) b1 = {b1[6:0], bits[i][0]};
                        else             b2 = {b2[6:0], bits[i][0]};
                     end
                  end
               end
               check("data_bits_driven", data_oe, 1'b1);
               check("ninth_bit_released", ack_oe, 1'b0);
               check("byte_device", b0, DEV);
               check("byte_address", b1, q_addr[rd_idx[3:0]]);
               check("byte_data", b2, q_data[rd_idx[3:0]]);
               check("dont_care_cycles", oe_low, 3 * 4 * Q);
               last0 = b0; last1 = b1; last2 = b2;
               rd_idx++;
               n_frames++;
               in_frame = 1'b0;
            end else begin
               check("siod_stable_while_sioc_high", o_siod, p_siod);
            end
         end
         p_sioc = o_sioc;
         p_siod = o_siod;
      end
   end

   task automatic wait_ready(output int n);
      n = 0;
      while (!o_ready && n < TXN + 100) begin
         @(posedge i_clk);
         #1;
         n++;
      end
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      repeat (3) @(negedge i_clk);
      check("reset_state", {o_ready, o_sioc, o_siod, o_siod_oe}, 4'b1111);
      i_reset_n = 1'b1;

      // Hand-computed points of the waveform model for 0x12/0x80.
      check("model_start_q2", wave(8'h12, 8'h80, 2), 3'b101);
      check("model_dev_bit6", wave(8'h12, 8'h80, 8), 3'b011);
      check("model_ninth_bit", wave(8'h12, 8'h80, 36), 3'b010);
      check("model_stop_q3", wave(8'h12, 8'h80, 115), 3'b111);
      repeat (2) @(negedge i_clk);

      // Single write with busy-time start pulses that must be ignored.
      i_address = 8'h12;
      i_data    = 8'h80;
      i_start   = 1'b1;
      @(posedge i_clk);
      #1;
      i_start = 1'b0;
      check("ready_low_after_accept", o_ready, 1'b0);
      n = 0;
      do begin
         if (n == 100 || n == 5000) begin
            i_start   = 1'b1;
            i_address = 8'hFF;
            i_data    = 8'hFF;
         end else begin
            i_start = 1'b0;
         end
         if (n == 103) check("ready_low_two_after_pulse", o_ready, 1'b0);
         @(posedge i_clk);
         #1;
         n++;
      end while (!o_ready && n < TXN + 100);
      check("ready_latency", n, 7440);
      check("frame1_bytes", {8'h00, last0, last1, last2}, 32'h00421280);

      // Reset during phase 2, then a clean write.
      repeat (3) @(negedge i_clk);
      i_address = 8'h55;
      i_data    = 8'hAA;
      i_start   = 1'b1;
      @(posedge i_clk);
      #1;
      i_start = 1'b0;
      repeat (48 * Q + 10) @(posedge i_clk);
      @(negedge i_clk);
      #2;
      i_reset_n = 1'b0;
      #1;
      check("reset_async_idle", {o_ready, o_sioc, o_siod, o_siod_oe}, 4'b1111);
      repeat (2) @(negedge i_clk);
      i_reset_n = 1'b1;
      repeat (2) @(negedge i_clk);
      i_address = 8'h3A;
      i_data    = 8'h04;
      i_start   = 1'b1;
      @(posedge i_clk);
      #1;
      i_start = 1'b0;
      wait_ready(n);
      check("ready_latency_after_reset", n, TXN);
      check("frame2_bytes", {8'h00, last0, last1, last2}, 32'h00423A04);

      // Back-to-back: i_start held across two transactions.
      @(negedge i_clk);
      i_address = 8'h0C;
      i_data    = 8'h5A;
      i_start   = 1'b1;
      @(posedge i_clk);
      #1;
      i_address = 8'h6B;
      i_data    = 8'hC3;
      wait_ready(n);
      check("b2b_first_latency", n, TXN);
      check("b2b_first_bytes", {8'h00, last0, last1, last2}, 32'h00420C5A);
      @(posedge i_clk);
      #1;
      check("b2b_ready_one_cycle", o_ready, 1'b0);
      i_start = 1'b0;
      wait_ready(n);
      check("b2b_second_latency", n, TXN);
      check("b2b_second_bytes", {8'h00, last0, last1, last2}, 32'h00426BC3);

      repeat (20) @(negedge i_clk);
      check("frames_decoded", n_frames, 4);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
